// File: rtl/bus_test_master.sv
// Self-checking bus traffic initiator: writes a patterned block, reads it back and counts
// mismatches and timeouts for LED/debug reporting.
module bus_test_master #(
    parameter logic [15:0] BASE_ADDR      = 16'h4000,
    parameter int unsigned NUM_WORDS      = 8,
    parameter logic [7:0]  SEED           = 8'h5A,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trigger,
    input  logic        m_grant,
    input  logic        m_ack,
    input  logic        m_split_ack,
    input  logic [7:0]  m_data_in,
    input  logic        m_data_in_valid,
    output logic        m_req,
    output logic [15:0] m_address_out,
    output logic        m_address_out_valid,
    output logic [7:0]  m_data_out,
    output logic        m_data_out_valid,
    output logic        m_rw,
    output logic        m_ready,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  error_count
);

    typedef enum logic [2:0] {
        StIdle, StReq, StAddr, StWdone, StRdata, StSplit, StNext, StFinish
    } state_e;

    localparam logic [7:0]  LastIdx     = 8'(NUM_WORDS - 1);
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    state_e      state;
    logic [7:0]  index;
    logic        phase_rd;
    logic [15:0] timer;

    logic [7:0] exp_data;
    logic [7:0] err_inc;
    logic       timed_out;

    assign exp_data  = SEED ^ index;
    assign err_inc   = (error_count == 8'hFF) ? 8'hFF : error_count + 8'd1;
    assign timed_out = (timer == TimeoutLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= StIdle;
            index               <= 8'd0;
            phase_rd            <= 1'b0;
            timer               <= 16'd0;
            m_req               <= 1'b0;
            m_address_out       <= 16'd0;
            m_address_out_valid <= 1'b0;
            m_data_out          <= 8'd0;
            m_data_out_valid    <= 1'b0;
            m_rw                <= 1'b1;
            m_ready             <= 1'b1;
            busy                <= 1'b0;
            done                <= 1'b0;
            pass                <= 1'b0;
            error_count         <= 8'd0;
        end else begin
            done  <= 1'b0;
            timer <= timer + 16'd1;
            case (state)
                StIdle: begin
                    timer <= 16'd0;
                    if (trigger) begin
                        error_count <= 8'd0;
                        pass        <= 1'b0;
                        index       <= 8'd0;
                        phase_rd    <= 1'b0;
                        busy        <= 1'b1;
                        m_req       <= 1'b1;
                        state       <= StReq;
                    end
                end
                StReq: begin
                    if (m_grant) begin
                        timer               <= 16'd0;
                        m_address_out       <= BASE_ADDR + {8'h00, index};
                        m_address_out_valid <= 1'b1;
                        m_rw                <= phase_rd;
                        if (!phase_rd) begin
                            m_data_out       <= exp_data;
                            m_data_out_valid <= 1'b1;
                        end
                        state <= StAddr;
                    end else if (timed_out) begin
                        m_req       <= 1'b0;
                        error_count <= err_inc;
                        timer       <= 16'd0;
                        state       <= StNext;
                    end
                end
                StAddr: begin
                    // Split wins over a simultaneous ack.
                    if (m_split_ack || m_ack) begin
                        m_address_out_valid <= 1'b0;
                        m_data_out_valid    <= 1'b0;
                        m_rw                <= 1'b1;
                        timer               <= 16'd0;
                        if (m_split_ack)   state <= StSplit;
                        else if (phase_rd) state <= StRdata;
                        else               state <= StWdone;
                    end else if (timed_out) begin
                        m_req               <= 1'b0;
                        m_address_out_valid <= 1'b0;
                        m_data_out_valid    <= 1'b0;
                        m_rw                <= 1'b1;
                        error_count         <= err_inc;
                        timer               <= 16'd0;
                        state               <= StNext;
                    end
                end
                StWdone: begin
                    m_req <= 1'b0;
                    timer <= 16'd0;
                    state <= StNext;
                end
                StRdata, StSplit: begin
                    // A split write completes on ack; every read completes on data.
                    if (phase_rd ? m_data_in_valid : (state == StSplit && m_ack)) begin
                        if (phase_rd && (m_data_in != exp_data)) error_count <= err_inc;
                        m_req <= 1'b0;
                        timer <= 16'd0;
                        state <= StNext;
                    end else if (timed_out) begin
                        m_req       <= 1'b0;
                        error_count <= err_inc;
                        timer       <= 16'd0;
                        state       <= StNext;
                    end
                end
                StNext: begin
                    timer <= 16'd0;
                    if (index == LastIdx) begin
                        if (!phase_rd) begin
                            phase_rd <= 1'b1;
                            index    <= 8'd0;
                            m_req    <= 1'b1;
                            state    <= StReq;
                        end else begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            pass  <= (error_count == 8'd0);
                            state <= StFinish;
                        end
                    end else begin
                        index <= index + 8'd1;
                        m_req <= 1'b1;
                        state <= StReq;
                    end
                end
                StFinish: begin
                    timer <= 16'd0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_test_master.sv
// Directed bench for bus_test_master with a small reactive slave (ideal, corrupting,
// splitting and non-acking behaviours).
module tb_bus_test_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trigger = 1'b0;
    logic        m_grant = 1'b0;
    logic        m_ack = 1'b0;
    logic        m_split_ack = 1'b0;
    logic [7:0]  m_data_in = 8'h00;
    logic        m_data_in_valid = 1'b0;
    logic        m_req;
    logic [15:0] m_address_out;
    logic        m_address_out_valid;
    logic [7:0]  m_data_out;
    logic        m_data_out_valid;
    logic        m_rw;
    logic        m_ready;
    logic        busy;
    logic        done;
    logic        pass;
    logic [7:0]  error_count;

    always #5 clk = ~clk;

    bus_test_master #(
        .BASE_ADDR     (16'h4000),
        .NUM_WORDS     (4),
        .SEED          (8'h5A),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .trigger            (trigger),
        .m_grant            (m_grant),
        .m_ack              (m_ack),
        .m_split_ack        (m_split_ack),
        .m_data_in          (m_data_in),
        .m_data_in_valid    (m_data_in_valid),
        .m_req              (m_req),
        .m_address_out      (m_address_out),
        .m_address_out_valid(m_address_out_valid),
        .m_data_out         (m_data_out),
        .m_data_out_valid   (m_data_out_valid),
        .m_rw               (m_rw),
        .m_ready            (m_ready),
        .busy               (busy),
        .done               (done),
        .pass               (pass),
        .error_count        (error_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Slave configuration and logs
    logic [15:0] noack_addr   = 16'hFFFF;
    logic [15:0] split_addr   = 16'hFFFF;
    logic [15:0] corrupt_addr = 16'hFFFF;
    logic [7:0]  mem [4];
    logic [15:0] wr_addr [8];
    logic [7:0]  wr_data [8];
    logic [15:0] rd_addr [8];
    int          wr_cnt, rd_cnt, wr_dv_bad, split_hits, split_reissue, done_cnt;
    logic        pending = 1'b0;
    logic [15:0] pend_addr = 16'h0000;
    int          split_cnt = 0;

    function automatic logic [7:0] rd_val(input logic [15:0] a);
        return (a == corrupt_addr) ? 8'h00 : mem[a[1:0]];
    endfunction

    task automatic clear_log();
        wr_cnt = 0; rd_cnt = 0; wr_dv_bad = 0; split_hits = 0; split_reissue = 0;
    endtask

    always @(negedge clk) if (done) done_cnt++;

    // Reactive slave: samples DUT outputs on the falling edge, drives responses for the next rise.
    initial begin
        forever begin
            @(negedge clk);
            m_ack = 1'b0;
            m_split_ack = 1'b0;
            m_data_in_valid = 1'b0;
            if (pending) begin
                m_data_in_valid = 1'b1;
                m_data_in = rd_val(pend_addr);
                pending = 1'b0;
            end else if (split_cnt != 0) begin
                if (m_address_out_valid) split_reissue++;
                split_cnt--;
                if (split_cnt == 0) begin
                    m_data_in_valid = 1'b1;
                    m_data_in = rd_val(pend_addr);
                end
            end else if (m_address_out_valid) begin
                if (!m_rw && m_address_out == noack_addr) begin
                    // stay silent to force a timeout
                end else if (m_rw && m_address_out == split_addr) begin
                    m_split_ack = 1'b1;
                    split_cnt = 4;
                    split_hits++;
                    pend_addr = m_address_out;
                end else begin
                    m_ack = 1'b1;
                    if (!m_rw) begin
                        if (!m_data_out_valid) wr_dv_bad++;
                        if (wr_cnt < 8) begin
                            wr_addr[wr_cnt] = m_address_out;
                            wr_data[wr_cnt] = m_data_out;
                        end
                        wr_cnt++;
                        mem[m_address_out[1:0]] = m_data_out;
                    end else begin
                        if (rd_cnt < 8) rd_addr[rd_cnt] = m_address_out;
                        rd_cnt++;
                        pending = 1'b1;
                        pend_addr = m_address_out;
                    end
                end
            end
            m_grant = m_req && !(split_cnt == 3 || split_cnt == 2);
        end
    end

    task automatic pulse_trigger();
        @(negedge clk) trigger = 1'b1;
        @(negedge clk) trigger = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        logic seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        check("done_seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_addr_valid(input int budget);
        logic seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = m_address_out_valid;
        end
        check("addr_valid_seen", {31'd0, seen}, 32'd1);
    endtask

    logic [7:0] exp_wdata [4] = '{8'h5A, 8'h5B, 8'h58, 8'h59};

    initial begin
        int d0;
        int cnt;
        for (int i = 0; i < 4; i++) mem[i] = 8'h00;
        clear_log();
        done_cnt = 0;

        // Reset values
        #12;
        check("rst_req", {31'd0, m_req}, 32'd0);
        check("rst_rw", {31'd0, m_rw}, 32'd1);
        check("rst_ready", {31'd0, m_ready}, 32'd1);
        check("rst_busy_done_pass", {29'd0, busy, done, pass}, 32'd0);
        check("rst_avalid", {31'd0, m_address_out_valid}, 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;

        // 1: reset in the middle of the address phase
        pulse_trigger();
        wait_addr_valid(20);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_req", {31'd0, m_req}, 32'd0);
        check("midrst_avalid_dvalid", {30'd0, m_address_out_valid, m_data_out_valid}, 32'd0);
        check("midrst_rw_ready", {30'd0, m_rw, m_ready}, 32'd3);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("midrst_no_done", done_cnt, 0);
        check("midrst_idle_req", {31'd0, m_req}, 32'd0);

        // 2: ideal slave
        clear_log();
        pulse_trigger();
        wait_done(300);
        check("t2_pass", {31'd0, pass}, 32'd1);
        check("t2_err", {24'd0, error_count}, 32'd0);
        check("t2_busy", {31'd0, busy}, 32'd0);
        check("t2_wr_cnt", wr_cnt, 4);
        check("t2_rd_cnt", rd_cnt, 4);
        check("t2_wr_dvalid", wr_dv_bad, 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_wr_addr%0d", i), {16'd0, wr_addr[i]}, 32'h4000 + i);
            check($sformatf("t2_wr_data%0d", i), {24'd0, wr_data[i]}, {24'd0, exp_wdata[i]});
            check($sformatf("t2_rd_addr%0d", i), {16'd0, rd_addr[i]}, 32'h4000 + i);
        end
        @(negedge clk);
        check("t2_done_pulse", {31'd0, done}, 32'd0);

        // 3: corrupted read of 4002
        clear_log();
        corrupt_addr = 16'h4002;
        pulse_trigger();
        wait_done(300);
        check("t3_err", {24'd0, error_count}, 32'd1);
        check("t3_pass", {31'd0, pass}, 32'd0);
        corrupt_addr = 16'hFFFF;
        repeat (3) @(negedge clk);
        check("t3_pass_held", {31'd0, pass}, 32'd0);

        // 6: restart clears errors; trigger while busy is ignored
        d0 = done_cnt;
        pulse_trigger();
        repeat (3) @(negedge clk);
        check("t6_err_cleared", {24'd0, error_count}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd1);
        pulse_trigger();
        wait_done(300);
        check("t6_pass", {31'd0, pass}, 32'd1);
        repeat (20) @(negedge clk);
        check("t6_one_done", done_cnt - d0, 1);
        check("t6_idle", {31'd0, busy}, 32'd0);

        // 4: split on the 4001 read
        clear_log();
        split_addr = 16'h4001;
        pulse_trigger();
        wait_done(300);
        check("t4_split_hits", split_hits, 1);
        check("t4_no_reissue", split_reissue, 0);
        check("t4_pass", {31'd0, pass}, 32'd1);
        check("t4_err", {24'd0, error_count}, 32'd0);
        split_addr = 16'hFFFF;

        // 5: no ack on the 4000 write -> timeout
        clear_log();
        noack_addr = 16'h4000;
        pulse_trigger();
        wait_addr_valid(20);
        cnt = 0;
        while (m_address_out_valid && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("t5_timeout_len", cnt, 16);
        cnt = 0;
        while (!m_req && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("t5_req_low", cnt, 1);
        wait_done(300);
        check("t5_err", {24'd0, error_count}, 32'd1);
        check("t5_pass", {31'd0, pass}, 32'd0);
        check("t5_wr_cnt", wr_cnt, 3);
        noack_addr = 16'hFFFF;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
